// File: rtl/jtag_link_pkg.sv
// jtag_link_pkg: word formats and frame constants shared by both ends of the JTAG FIFO link
package jtag_link_pkg;
    localparam int WORK_BITS   = 352;
    localparam int WORK_BYTES  = 44;
    localparam int NONCE_BYTES = 4;
    localparam logic [3:0] TAG_FIRST = 4'b1111;
    localparam logic [3:0] TAG_LAST  = 4'b0001;
    localparam logic WB_START = 1'b0;
    localparam logic WB_CONT  = 1'b1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
endpackage

// File: rtl/jtag_nonce_unpack.sv
// jtag_nonce_unpack: checks the tag sequence of {tag, byte} nonce words and reassembles 32-bit nonces
module jtag_nonce_unpack
    import jtag_link_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             hash_clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [11:0]      data,
    output logic             nonce_valid,
    output logic [31:0]      nonce,
    output logic             nonce_err,
    output logic [CNT_W-1:0] nonce_count,
    output logic [7:0]       err_count
);
    logic [3:0] exp_tag;
    logic [8*(NONCE_BYTES-1)-1:0] acc;
    logic [3:0] tag;
    logic [7:0] dbyte;
    logic first, next, bad, done;
    always_comb begin
        tag   = data[11:8];
        dbyte = data[7:0];
        first = tag == TAG_FIRST;
        next  = !first && tag == exp_tag;
        bad   = rd_en && (first ? exp_tag != TAG_FIRST : !next);
        done  = rd_en && next && tag == TAG_LAST;
    end
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_tag     <= TAG_FIRST;
            acc         <= '0;
            nonce_valid <= 1'b0;
            nonce       <= '0;
            nonce_err   <= 1'b0;
            nonce_count <= '0;
            err_count   <= '0;
        end else begin
            nonce_valid <= done;
            nonce_err   <= bad;
            if (done) begin
                nonce       <= {dbyte, acc};
                nonce_count <= nonce_count + CNT_W'(1);
            end
            if (bad) err_count <= err_count + {7'd0, ~&err_count};
            if (rd_en) begin
                if (first) begin
                    acc[7:0] <= dbyte;
                    exp_tag  <= TAG_FIRST >> 1;
                end else if (next && !done) begin
                    acc[(tag == 4'b0111 ? 8 : 16) +: 8] <= dbyte;
                    exp_tag <= exp_tag >> 1;
                end else begin
                    exp_tag <= TAG_FIRST;
                    if (!next) acc <= '0;
                end
            end
        end
    end
endmodule

// File: rtl/jtag_host_link.sv
// jtag_host_link: host end of the JTAG FIFO link; serializes work units and reassembles golden nonces
module jtag_host_link
    import jtag_link_pkg::*;
#(
    parameter int WORK_BYTES = 44,
    parameter int CNT_W      = 16
) (
    input  logic                 hash_clk,
    input  logic                 rst_n,
    input  logic                 work_valid,
    output logic                 work_ready,
    input  logic [WORK_BITS-1:0] work_data,
    output logic                 wfifo_wr_en,
    output logic [8:0]           wfifo_data,
    input  logic                 wfifo_full,
    output logic                 nfifo_rd_en,
    input  logic [11:0]          nfifo_data,
    input  logic                 nfifo_empty,
    output logic                 nonce_valid,
    output logic [31:0]          nonce,
    output logic                 nonce_err,
    output logic [CNT_W-1:0]     nonce_count,
    output logic [7:0]           err_count
);
    localparam int IDX_W = $clog2(WORK_BYTES);
    logic [0:0] state;
    logic live;
    logic [IDX_W-1:0] idx;
    logic [WORK_BITS-1:0] shreg;
    assign work_ready  = live && state == ST_IDLE;
    assign wfifo_wr_en = state == ST_SEND && !wfifo_full;
    assign wfifo_data  = {((idx != '0) ? WB_CONT : WB_START), shreg[WORK_BITS-1 -: 8]};
    assign nfifo_rd_en = live && !nfifo_empty;
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            live  <= 1'b0;
            state <= ST_IDLE;
            idx   <= '0;
            shreg <= '0;
        end else begin
            live <= 1'b1;
            if (work_valid && work_ready) begin
                state <= ST_SEND;
                idx   <= '0;
                shreg <= work_data;
            end else if (wfifo_wr_en) begin
                shreg <= shreg << 8;
                idx   <= idx + IDX_W'(1);
                if (idx == IDX_W'(WORK_BYTES - 1)) state <= ST_IDLE;
            end
        end
    end
    jtag_nonce_unpack #(.CNT_W(CNT_W)) u_unpack (
        .hash_clk    (hash_clk),
        .rst_n       (rst_n),
        .rd_en       (nfifo_rd_en),
        .data        (nfifo_data),
        .nonce_valid (nonce_valid),
        .nonce       (nonce),
        .nonce_err   (nonce_err),
        .nonce_count (nonce_count),
        .err_count   (err_count)
    );
endmodule

// File: tb/tb_jtag_host_link.sv
// tb_jtag_host_link: randomized self-checking bench with a frame-level reference model
module tb_jtag_host_link;
    logic hash_clk = 1'b0;
    logic rst_n = 1'b0;
    logic work_valid = 1'b0;
    logic wfifo_full = 1'b0;
    logic [351:0] work_data = '0;
    logic work_ready, wfifo_wr_en, nfifo_rd_en, nfifo_empty, nonce_valid, nonce_err;
    logic [8:0] wfifo_data;
    logic [11:0] nfifo_data;
    logic [31:0] nonce;
    logic [15:0] nonce_count;
    logic [7:0] err_count;
    int checks = 0, failures = 0;
    logic [11:0] nmem [1024];
    int nhead = 0, ntail = 0;
    logic [8:0] wq[$];
    logic [33:0] evq[$], expq[$];
    int viol = 0;
    int m_pos = 0, m_ncnt = 0, m_ecnt = 0;
    logic [7:0] m_b [4];

    jtag_host_link dut (
        .hash_clk    (hash_clk),
        .rst_n       (rst_n),
        .work_valid  (work_valid),
        .work_ready  (work_ready),
        .work_data   (work_data),
        .wfifo_wr_en (wfifo_wr_en),
        .wfifo_data  (wfifo_data),
        .wfifo_full  (wfifo_full),
        .nfifo_rd_en (nfifo_rd_en),
        .nfifo_data  (nfifo_data),
        .nfifo_empty (nfifo_empty),
        .nonce_valid (nonce_valid),
        .nonce       (nonce),
        .nonce_err   (nonce_err),
        .nonce_count (nonce_count),
        .err_count   (err_count)
    );

    always #5 hash_clk = ~hash_clk;
    assign nfifo_empty = (nhead == ntail);
    assign nfifo_data  = nmem[nhead % 1024];
    always @(posedge hash_clk) if (nfifo_rd_en) nhead <= nhead + 1;
    always @(negedge hash_clk) begin
        if (wfifo_wr_en) begin
            if (wfifo_full) viol++;
            wq.push_back(wfifo_data);
        end
        if (nonce_valid || nonce_err) evq.push_back({nonce_valid, nonce_err, nonce});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] exp_word(input logic [351:0] d, input int i);
        return {i != 0, d[351-8*i -: 8]};
    endfunction

    task automatic model_err;
        expq.push_back({2'b01, 32'h0});
        if (m_ecnt < 255) m_ecnt++;
    endtask

    task automatic push_word(input logic [3:0] t, input logic [7:0] b);
        nmem[ntail % 1024] = {t, b};
        ntail++;
        if (t == 4'hF) begin
            if (m_pos != 0) model_err();
            m_b[0] = b;
            m_pos = 1;
        end else if (m_pos != 0 && t == (4'hF >> m_pos)) begin
            m_b[m_pos] = b;
            m_pos++;
            if (m_pos == 4) begin
                expq.push_back({2'b10, m_b[3], m_b[2], m_b[1], m_b[0]});
                m_ncnt++;
                m_pos = 0;
            end
        end else begin
            model_err();
            m_pos = 0;
        end
    endtask

    task automatic push_nonce(input logic [31:0] v);
        push_word(4'hF, v[7:0]);
        push_word(4'h7, v[15:8]);
        push_word(4'h3, v[23:16]);
        push_word(4'h1, v[31:24]);
    endtask

    task automatic send_work(input logic [351:0] d, output logic ok);
        ok = 1'b0;
        @(posedge hash_clk); #1;
        for (int i = 0; i < 3000; i++) begin
            if (work_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge hash_clk); #1;
        end
        if (ok) begin
            work_data = d;
            work_valid = 1'b1;
            @(posedge hash_clk); #1;
            work_valid = 1'b0;
        end
    endtask

    task automatic wait_words(input int n, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge hash_clk);
            if (wq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge hash_clk);
            if (nhead == ntail) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge hash_clk);
        @(posedge hash_clk); #1;
    endtask

    task automatic test_reset;
        logic [69:0] v;
        repeat (3) @(negedge hash_clk);
        v = {work_ready, wfifo_wr_en, wfifo_data, nfifo_rd_en, nonce_valid, nonce, nonce_err, nonce_count, err_count};
        checks++;
        if (v !== 70'd0) begin failures++; $display("FAIL reset_outputs: got %h want 0", v); end
        @(posedge hash_clk); #1 rst_n = 1'b1;
        @(posedge hash_clk); #1;
        checks++;
        if (work_ready !== 1'b1) begin failures++; $display("FAIL ready_after_release: got %b want 1", work_ready); end
    endtask

    task automatic test_work_frame;
        logic [351:0] d;
        logic ok;
        int low;
        for (int i = 0; i < 44; i++) d[351-8*i -: 8] = 8'(i);
        wq.delete();
        send_work(d, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL frame_accept: got timeout want accept"); end
        low = 0;
        while (work_ready !== 1'b1 && low < 200) begin
            @(negedge hash_clk);
            if (work_ready !== 1'b1) low++;
        end
        checks++;
        if (low != 44) begin failures++; $display("FAIL ready_low_cycles: got %0d want 44", low); end
        checks++;
        if (wq.size() != 44) begin failures++; $display("FAIL frame_len: got %0d want 44", wq.size()); end
        for (int i = 0; i < wq.size() && i < 44; i++) begin
            checks++;
            if (wq[i] !== exp_word(d, i)) begin failures++; $display("FAIL frame_word[%0d]: got %h want %h", i, wq[i], exp_word(d, i)); end
        end
        if (wq.size() == 44) begin
            checks++;
            if (wq[0] !== 9'h000 || wq[43] !== 9'h12B) begin failures++; $display("FAIL frame_ends: got %h/%h want 000/12b", wq[0], wq[43]); end
        end
        @(posedge hash_clk); #1;
    endtask

    task automatic test_backpressure;
        logic [351:0] d;
        logic ok;
        for (int i = 0; i < 44; i++) d[351-8*i -: 8] = 8'(i);
        wq.delete();
        viol = 0;
        send_work(d, ok);
        wait_words(10, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_reach10: got timeout want 10 writes"); end
        #1 wfifo_full = 1'b1;
        repeat (5) begin
            @(negedge hash_clk);
            checks++;
            if (wfifo_wr_en !== 1'b0 || wfifo_data !== 9'h10A) begin
                failures++;
                $display("FAIL bp_hold: got wr_en=%b data=%h want wr_en=0 data=10a", wfifo_wr_en, wfifo_data);
            end
        end
        @(posedge hash_clk); #1 wfifo_full = 1'b0;
        wait_words(44, ok);
        repeat (2) @(negedge hash_clk);
        checks++;
        if (wq.size() != 44 || viol != 0) begin failures++; $display("FAIL bp_total: got %0d writes %0d while full want 44/0", wq.size(), viol); end
        for (int i = 0; i < wq.size() && i < 44; i++) begin
            checks++;
            if (wq[i] !== exp_word(d, i)) begin failures++; $display("FAIL bp_word[%0d]: got %h want %h", i, wq[i], exp_word(d, i)); end
        end
        @(posedge hash_clk); #1;
    endtask

    task automatic test_nonce;
        logic ok;
        evq.delete();
        push_word(4'hF, 8'hEF);
        push_word(4'h7, 8'hBE);
        push_word(4'h3, 8'hAD);
        push_word(4'h1, 8'hDE);
        drain(ok);
        checks++;
        if (!ok || evq.size() != 1) begin failures++; $display("FAIL nonce_events: got %0d want 1", evq.size()); end
        else begin
            checks++;
            if (evq[0] !== {2'b10, 32'hDEADBEEF}) begin failures++; $display("FAIL nonce_value: got %h want 2deadbeef", evq[0]); end
        end
        checks++;
        if (nonce_count !== 16'd1 || nonce !== 32'hDEADBEEF) begin failures++; $display("FAIL nonce_count: got %0d/%h want 1/deadbeef", nonce_count, nonce); end
    endtask

    task automatic test_bad_tag;
        logic ok;
        evq.delete();
        push_word(4'hF, 8'hAA);
        push_word(4'h3, 8'hBB);
        push_nonce(32'h11223344);
        drain(ok);
        checks++;
        if (!ok || evq.size() != 2) begin failures++; $display("FAIL bad_events: got %0d want 2", evq.size()); end
        else begin
            checks++;
            if (evq[0][33:32] !== 2'b01 || evq[1] !== {2'b10, 32'h11223344}) begin failures++; $display("FAIL bad_seq: got %h,%h want err then 11223344", evq[0], evq[1]); end
        end
        checks++;
        if (err_count !== 8'd1 || nonce_count !== 16'd2) begin failures++; $display("FAIL bad_counts: got %0d/%0d want 1/2", err_count, nonce_count); end
    endtask

    task automatic test_restart;
        logic ok;
        evq.delete();
        push_word(4'hF, 8'h01);
        push_word(4'h7, 8'h02);
        push_nonce(32'h12345678);
        drain(ok);
        checks++;
        if (!ok || evq.size() != 2) begin failures++; $display("FAIL restart_events: got %0d want 2", evq.size()); end
        else begin
            checks++;
            if (evq[0][33:32] !== 2'b01 || evq[1] !== {2'b10, 32'h12345678}) begin failures++; $display("FAIL restart_seq: got %h,%h want err then 12345678", evq[0], evq[1]); end
        end
        checks++;
        if (err_count !== 8'd2 || nonce_count !== 16'd3) begin failures++; $display("FAIL restart_counts: got %0d/%0d want 2/3", err_count, nonce_count); end
    endtask

    task automatic test_random;
        logic [351:0] frames[$];
        logic a_done, ok_a, ok_w, ok_d;
        int sent_fail;
        a_done = 1'b0;
        sent_fail = 0;
        ok_w = 1'b0;
        wq.delete();
        evq.delete();
        expq.delete();
        viol = 0;
        @(posedge hash_clk); #1;
        fork
            begin
                logic [351:0] d;
                for (int f = 0; f < 3; f++) begin
                    for (int k = 0; k < 11; k++) d[32*k +: 32] = $urandom;
                    frames.push_back(d);
                    send_work(d, ok_a);
                    if (!ok_a) sent_fail++;
                end
                wait_words(132, ok_w);
                a_done = 1'b1;
            end
            begin
                for (int n = 0; n < 4000 && !a_done; n++) begin
                    @(posedge hash_clk); #1;
                    wfifo_full = ($urandom_range(0, 2) == 0);
                end
                wfifo_full = 1'b0;
            end
            begin
                int k;
                logic [3:0] t;
                k = 0;
                for (int n = 0; n < 48; n++) begin
                    t = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(4'hF >> (k % 4));
                    k++;
                    push_word(t, 8'($urandom));
                    if ($urandom_range(0, 1) == 1) begin
                        @(posedge hash_clk); #1;
                    end
                end
            end
        join
        drain(ok_d);
        checks++;
        if (sent_fail != 0 || !ok_w || !ok_d) begin failures++; $display("FAIL rand_progress: got send_fail=%0d words=%0d drained=%b want 0/132/1", sent_fail, wq.size(), ok_d); end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL rand_write_when_full: got %0d want 0", viol); end
        checks++;
        if (wq.size() != 132) begin failures++; $display("FAIL rand_words: got %0d want 132", wq.size()); end
        for (int i = 0; i < wq.size() && i < 132; i++) begin
            checks++;
            if (wq[i] !== exp_word(frames[i/44], i % 44)) begin failures++; $display("FAIL rand_word[%0d]: got %h want %h", i, wq[i], exp_word(frames[i/44], i % 44)); end
        end
        checks++;
        if (evq.size() != expq.size()) begin failures++; $display("FAIL rand_event_count: got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            checks++;
            if (evq[i][33:32] !== expq[i][33:32] || (expq[i][33] && evq[i][31:0] !== expq[i][31:0])) begin
                failures++;
                $display("FAIL rand_event[%0d]: got %h want %h", i, evq[i], expq[i]);
            end
        end
        checks++;
        if (nonce_count !== 16'(m_ncnt) || err_count !== 8'(m_ecnt)) begin failures++; $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", nonce_count, err_count, m_ncnt, m_ecnt); end
    endtask

    task automatic test_reset_mid_send;
        logic [351:0] d;
        logic ok;
        for (int i = 0; i < 44; i++) d[351-8*i -: 8] = 8'(i);
        wq.delete();
        send_work(d, ok);
        wait_words(20, ok);
        #1;
        checks++;
        if (wfifo_wr_en !== 1'b1 || wfifo_data !== 9'h114) begin failures++; $display("FAIL mid_pre: got %b/%h want 1/114", wfifo_wr_en, wfifo_data); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wfifo_wr_en !== 1'b0 || work_ready !== 1'b0 || nonce_count !== 16'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: got wr=%b rdy=%b cnt=%0d err=%0d want 0/0/0/0", wfifo_wr_en, work_ready, nonce_count, err_count);
        end
        m_pos = 0;
        m_ncnt = 0;
        m_ecnt = 0;
        @(posedge hash_clk); #1 rst_n = 1'b1;
        @(posedge hash_clk); #1;
        checks++;
        if (work_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b want 1", work_ready); end
        for (int k = 0; k < 11; k++) d[32*k +: 32] = $urandom;
        wq.delete();
        evq.delete();
        expq.delete();
        send_work(d, ok);
        push_nonce(32'hAABBCCDD);
        wait_words(44, ok);
        drain(ok);
        checks++;
        if (wq.size() != 44 || wq[0][8] !== 1'b0) begin failures++; $display("FAIL mid_restart_frame: got len=%0d first=%h want 44 and bit8=0", wq.size(), wq.size() ? wq[0] : 9'h1FF); end
        for (int i = 0; i < wq.size() && i < 44; i++) begin
            checks++;
            if (wq[i] !== exp_word(d, i)) begin failures++; $display("FAIL mid_word[%0d]: got %h want %h", i, wq[i], exp_word(d, i)); end
        end
        checks++;
        if (evq.size() != 1 || nonce !== 32'hAABBCCDD || nonce_count !== 16'd1) begin
            failures++;
            $display("FAIL mid_nonce: got %0d events %h cnt %0d want 1 aabbccdd 1", evq.size(), nonce, nonce_count);
        end
    endtask

    initial begin
        test_reset();
        test_work_frame();
        test_backpressure();
        test_nonce();
        test_bad_tag();
        test_restart();
        test_random();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
